ecc_mem_ctrl: RTL and testbench

//  Parametrised SECDED-protected memory with req/rsp valid-ready handshake, replacing the fixed 8x128 hasio model.

---
 rtl/ecc_pkg.sv | 29 ++
 rtl/ecc_mem_ctrl_if.sv | 35 +++
 rtl/ecc_mem_ctrl_codec.sv | 49 ++++
 rtl/ecc_mem_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ecc_mem_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_pkg.sv
// SECDED memory controller: shared types and code-construction helpers.
// Column codes skip powers of two so check bits stay one-hot.
package ecc_pkg;

  function automatic int ecc_pw(int dw);
    return $clog2(1 + dw + $clog2(1 + dw)) + 1;
  endfunction

  // Low bits: i-th non-power-of-two >= 3. Top bit forces odd weight.
  function automatic logic [31:0] col_code(int i, int pw);
    logic [31:0] low;
    logic [31:0] v;
    low = 32'(i + 1 + $clog2(2 + i + $clog2(2 + i)));
    v = '0;
    for (int b = 0; b < pw - 1; b++) v[b] = low[b];
    v[pw-1] = ~^v;
    return v;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_WB   = 3'd3,
    S_RSP  = 3'd4,
    S_SRD  = 3'd5
  } state_t;

endpackage

// File: rtl/ecc_mem_ctrl_if.sv
// Request/response handshake bundle for the SECDED memory.
// Master drives requests, slave returns read responses.
interface ecc_mem_ctrl_if #(
  parameter int DW = 128,
  parameter int AW = 3,
  parameter int PW = ecc_pkg::ecc_pw(DW)
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW+PW-1:0] inj_flip;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_sec;
  logic          rsp_ded;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, inj_flip, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_sec, rsp_ded
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, inj_flip, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_sec, rsp_ded
  );

endinterface

// File: rtl/ecc_mem_ctrl_codec.sv
// Combinational SECDED encoder and decoder.
// Syndrome odd -> single error, even nonzero -> double.
module secded_codec
  import ecc_pkg::*;
#(
  parameter int DW = 128,
  parameter int PW = ecc_pw(DW)
) (
  input  logic [DW-1:0] data,
  input  logic [PW-1:0] chk_rd,
  output logic [PW-1:0] chk,
  output logic [DW-1:0] cdata,
  output logic          sec,
  output logic          ded
);

  logic [PW-1:0] col [DW];
  logic [PW-1:0] syn;

  for (genvar g = 0; g < DW; g++) begin : g_col
    localparam logic [31:0] C = col_code(g, PW);
    assign col[g] = C[PW-1:0];
  end

  always_comb begin
    chk = '0;
    for (int i = 0; i < DW; i++)
      chk = chk ^ (col[i] & {PW{data[i]}});
  end

  assign syn = chk ^ chk_rd;

  // A one-hot syndrome matches no column: check-bit error.
  always_comb begin
    cdata = data;
    sec   = 1'b0;
    ded   = 1'b0;
    if (syn != '0) begin
      if (^syn) begin
        sec = 1'b1;
        for (int i = 0; i < DW; i++)
          if (syn == col[i]) cdata[i] = ~data[i];
      end else begin
        ded = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ecc_mem_ctrl.sv
// SECDED-protected word memory with scrub-on-read,
// idle-time patrol scrubbing and saturating error counters.
module ecc_mem_ctrl
  import ecc_pkg::*;
#(
  parameter int DW        = 128,
  parameter int AW        = 3,
  parameter int SCRUB_INT = 256,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  ecc_mem_ctrl_if.slave bus,
  input  logic          scrub_en,
  input  logic          clr_cnt,
  output logic [CW-1:0] cnt_sec,
  output logic [CW-1:0] cnt_ded,
  output logic          err_pulse
);

  localparam int PW    = ecc_pw(DW);
  localparam int NW    = DW + PW;
  localparam int DEPTH = 2 ** AW;
  localparam int TW    = $clog2(SCRUB_INT);
  localparam logic [TW-1:0] T_END = TW'(SCRUB_INT - 1);

  state_t        state;
  logic [AW-1:0] op_addr;
  logic [AW-1:0] scrub_addr;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [NW-1:0] flip_q;
  logic          scrub_q;
  logic          sec_q;
  logic          ded_q;
  logic          rdy_q;
  logic          vld_q;
  logic [TW-1:0] timer;

  logic [NW-1:0] mem [DEPTH];
  logic [NW-1:0] rd_word;
  logic [DW-1:0] w_data;
  logic [PW-1:0] w_chk;
  logic [DW-1:0] r_cdata;
  logic          r_sec;
  logic          r_ded;
  logic          detect;
  logic          scrub_go;

  logic [PW-1:0] unused_r_chk;
  logic [DW-1:0] unused_w_cdata;
  logic          unused_w_sec;
  logic          unused_w_ded;

  assign rd_word = mem[op_addr];
  assign w_data  = (state == S_WB) ? rdata_q : wdata_q;
  assign detect  = (state == S_RD) || (state == S_SRD);
  assign scrub_go = (state == S_IDLE) && scrub_en &&
                    !bus.req_valid && (timer == T_END);

  secded_codec #(.DW(DW), .PW(PW)) u_wr_codec (
    .data   (w_data),
    .chk_rd ('0),
    .chk    (w_chk),
    .cdata  (unused_w_cdata),
    .sec    (unused_w_sec),
    .ded    (unused_w_ded)
  );

  secded_codec #(.DW(DW), .PW(PW)) u_rd_codec (
    .data   (rd_word[DW-1:0]),
    .chk_rd (rd_word[DW +: PW]),
    .chk    (unused_r_chk),
    .cdata  (r_cdata),
    .sec    (r_sec),
    .ded    (r_ded)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == S_WR)
        mem[op_addr] <= {w_chk, w_data} ^ flip_q;
      else if (state == S_WB)
        mem[op_addr] <= {w_chk, w_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clr_cnt) begin
      cnt_sec <= '0;
      cnt_ded <= '0;
    end else begin
      if (detect && r_sec && !(&cnt_sec))
        cnt_sec <= cnt_sec + 1'b1;
      if (detect && r_ded && !(&cnt_ded))
        cnt_ded <= cnt_ded + 1'b1;
    end
  end

  // A pending request holds the timer at terminal count.
  always_ff @(posedge clk) begin
    if (!reset || !scrub_en || scrub_go)
      timer <= '0;
    else if (state == S_IDLE && timer != T_END)
      timer <= timer + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      rdy_q      <= 1'b1;
      vld_q      <= 1'b0;
      sec_q      <= 1'b0;
      ded_q      <= 1'b0;
      rdata_q    <= '0;
      err_pulse  <= 1'b0;
      scrub_addr <= '0;
      scrub_q    <= 1'b0;
      op_addr    <= '0;
      wdata_q    <= '0;
      flip_q     <= '0;
    end else begin
      err_pulse <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_addr <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            flip_q  <= bus.inj_flip;
            scrub_q <= 1'b0;
            rdy_q   <= 1'b0;
            state   <= bus.req_we ? S_WR : S_RD;
          end else if (scrub_go) begin
            op_addr    <= scrub_addr;
            scrub_addr <= scrub_addr + 1'b1;
            scrub_q    <= 1'b1;
            rdy_q      <= 1'b0;
            state      <= S_SRD;
          end
        end
        S_WR: begin
          rdy_q <= 1'b1;
          state <= S_IDLE;
        end
        S_RD, S_SRD: begin
          rdata_q   <= r_cdata;
          err_pulse <= r_ded;
          if (!scrub_q) begin
            sec_q <= r_sec;
            ded_q <= r_ded;
          end
          if (r_sec) begin
            state <= S_WB;
          end else if (scrub_q) begin
            rdy_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            vld_q <= 1'b1;
            state <= S_RSP;
          end
        end
        S_WB: begin
          if (scrub_q) begin
            rdy_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            vld_q <= 1'b1;
            state <= S_RSP;
          end
        end
        S_RSP: begin
          if (bus.rsp_ready) begin
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_sec   = sec_q;
  assign bus.rsp_ded   = ded_q;

endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// Scoreboard bench for ecc_mem_ctrl: a word/flip-mask model
// predicts each read response and the error counters.
module tb_ecc_mem_ctrl;
  import ecc_pkg::*;

  localparam int DW = 128;
  localparam int AW = 3;
  localparam int SCRUB_INT = 16;
  localparam int CW = 4;
  localparam int PW = ecc_pw(DW);
  localparam int NW = DW + PW;
  localparam int DEPTH = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic scrub_en = 1'b0;
  logic clr_cnt = 1'b0;
  logic [CW-1:0] cnt_sec;
  logic [CW-1:0] cnt_ded;
  logic err_pulse;

  ecc_mem_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  ecc_mem_ctrl #(
    .DW(DW), .AW(AW), .SCRUB_INT(SCRUB_INT), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .scrub_en(scrub_en), .clr_cnt(clr_cnt),
    .cnt_sec(cnt_sec), .cnt_ded(cnt_ded),
    .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic sec;
    logic ded;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_accept = 0;
  int wait_cyc = 0;
  int rdy_mode = 0;
  int e_sec = 0;
  int e_ded = 0;
  int e_pulse = 0;
  int pulse_cnt = 0;
  logic prev_v = 1'b0;
  logic [DW-1:0] m_data [DEPTH];
  logic [NW-1:0] m_flip [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic int sat(int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [NW-1:0] mk_flip(int w);
    logic [NW-1:0] m;
    m = '0;
    while ($countones(m) < w) m[$urandom_range(NW-1, 0)] = 1'b1;
    return m;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) bus.rsp_ready = 1'b1;
    else if (rdy_mode == 1) bus.rsp_ready = 1'($urandom_range(1, 0));
    else bus.rsp_ready = 1'b0;
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.rsp_valid && !prev_v) begin
      if (exp_q.size() == 0)
        chk("rsp_unexpected", DW'(1), DW'(0));
      else
        chk("rsp_latency", DW'(cyc - last_accept + 1), DW'(exp_q[0].lat));
    end
    prev_v = bus.rsp_valid;
    if (bus.rsp_valid && bus.rsp_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rsp_rdata", bus.rsp_rdata, e.data);
      chk("rsp_sec", DW'(bus.rsp_sec), DW'(e.sec));
      chk("rsp_ded", DW'(bus.rsp_ded), DW'(e.ded));
    end
    if (err_pulse === 1'b1) pulse_cnt++;
  end

  task automatic do_req(input logic we, input int a, input logic [DW-1:0] d,
                        input logic [NW-1:0] f, input bit push);
    int n;
    int w;
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = AW'(a);
    bus.req_wdata = d;
    bus.inj_flip = f;
    n = 0;
    while (n <= 100) begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
    end
    if (n > 100) begin
      chk("req_timeout", DW'(n), DW'(0));
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      last_accept = cyc;
      wait_cyc = n;
      if (we) begin
        m_data[a] = d;
        m_flip[a] = f;
      end else if (push) begin
        w = $countones(m_flip[a]);
        e.data = (w == 2) ? (m_data[a] ^ m_flip[a][DW-1:0]) : m_data[a];
        e.sec = (w == 1);
        e.ded = (w == 2);
        e.lat = (w == 1) ? 3 : 2;
        if (w == 1) begin
          m_flip[a] = '0;
          e_sec = sat(e_sec + 1);
        end
        if (w == 2) begin
          e_ded = sat(e_ded + 1);
          e_pulse++;
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("rsp_timeout", DW'(exp_q.size()), DW'(0));
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d,
                    input logic [NW-1:0] f);
    do_req(1'b1, a, d, f, 1'b0);
  endtask

  task automatic rd(input int a);
    do_req(1'b0, a, '0, '0, 1'b1);
    wait_rsp();
  endtask

  task automatic chk_cnt();
    chk("cnt_sec", DW'(cnt_sec), DW'(e_sec));
    chk("cnt_ded", DW'(cnt_ded), DW'(e_ded));
    chk("err_pulses", DW'(pulse_cnt), DW'(e_pulse));
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    e_sec = 0;
    e_ded = 0;
  endtask

  initial begin : wdog
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    logic [NW-1:0] f;
    logic [DW-1:0] d;
    logic [DW-1:0] snap;
    logic snap_sec;
    int n;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.inj_flip = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", DW'(bus.req_ready), DW'(1));
    chk("rst_rsp_valid", DW'(bus.rsp_valid), DW'(0));
    chk("rst_rsp_rdata", bus.rsp_rdata, '0);
    chk("rst_rsp_flags", DW'({bus.rsp_sec, bus.rsp_ded}), DW'(0));
    chk("rst_err_pulse", DW'(err_pulse), DW'(0));
    chk_cnt();
    @(posedge clk); #1;

    for (int a = 0; a < DEPTH; a++) wr(a, rnd_data(), '0);

    wr(0, 128'hf0f0f0f0_0f0f0f0f_a0a0a0a0_0a0a0a0a, '0);
    rd(0);

    f = '0; f[5] = 1'b1;
    wr(1, rnd_data(), f);
    rd(1);
    chk_cnt();
    rd(1);

    f = '0; f[5] = 1'b1; f[77] = 1'b1;
    wr(2, rnd_data(), f);
    rd(2);
    chk_cnt();
    rd(2);
    chk_cnt();

    f = '0; f[DW+2] = 1'b1;
    wr(3, rnd_data(), f);
    rdy_mode = 2;
    do_req(1'b0, 3, '0, '0, 1'b1);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    snap = bus.rsp_rdata;
    snap_sec = bus.rsp_sec;
    chk("hold_sec", DW'(snap_sec), DW'(1));
    chk("hold_data", snap, m_data[3]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", DW'(bus.rsp_valid), DW'(1));
      chk("hold_rdata", bus.rsp_rdata, snap);
    end
    rdy_mode = 0;
    wait_rsp();
    chk_cnt();

    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(1, 0) == 1)
        wr($urandom_range(DEPTH-1, 0), rnd_data(),
           mk_flip($urandom_range(2, 0)));
      else
        rd($urandom_range(DEPTH-1, 0));
    end
    rdy_mode = 0;
    @(posedge clk); #1;
    chk_cnt();

    wr(2, rnd_data(), mk_flip(2));
    repeat (20) rd(2);
    chk_cnt();
    for (int i = 0; i < 20; i++) begin
      wr(5, rnd_data(), mk_flip(1));
      rd(5);
    end
    chk_cnt();
    pulse_clr();
    chk_cnt();

    wr(5, rnd_data(), mk_flip(1));
    rd(5);
    wr(5, rnd_data(), mk_flip(1));
    do_req(1'b0, 5, '0, '0, 1'b1);
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    e_sec = 0;
    e_ded = 0;
    wait_rsp();
    chk_cnt();

    for (int a = 0; a < DEPTH; a++) wr(a, rnd_data(), '0);
    f = '0; f[100] = 1'b1;
    wr(6, rnd_data(), f);
    f = '0; f[DW+4] = 1'b1;
    wr(4, rnd_data(), f);
    pulse_clr();
    scrub_en = 1'b1;
    repeat (300) @(posedge clk);
    #1 scrub_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    e_sec = 2;
    m_flip[6] = '0;
    m_flip[4] = '0;
    chk_cnt();
    rd(6);
    rd(4);
    chk_cnt();

    scrub_en = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    do_req(1'b0, 0, '0, '0, 1'b1);
    chk("req_vs_scrub_wait", DW'(wait_cyc), DW'(0));
    wait_rsp();
    scrub_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    do_req(1'b0, 0, '0, '0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    e_sec = 0;
    e_ded = 0;
    @(negedge clk);
    chk("rst_rd_rsp_valid", DW'(bus.rsp_valid), DW'(0));
    chk("rst_rd_req_ready", DW'(bus.req_ready), DW'(1));
    chk_cnt();
    @(posedge clk); #1;
    rd(0);
    chk_cnt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
